// File: rtl/rw_fifo_pkg.sv
// Shared defaults for the rw_fifo slice: word width, depth and occupancy-count width.
// A small helper lets the top reject a non power-of-two depth at elaboration.
package rw_fifo_pkg;

    localparam int DEF_DATA_W = 256;
    localparam int DEF_DEPTH  = 512;
    localparam int DEF_CNT_W  = 10;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rw_fifo_mem.sv
// Simple dual-port storage for rw_fifo: one synchronous write port and one registered,
// read-enabled read port, written so it maps onto a block RAM with an output register.
module rw_fifo_mem
    import rw_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] ram [DEPTH];

    // The array itself is never cleared; only the caller's pointers make old words unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= ram[raddr];
        end
    end

endmodule

// File: rtl/rw_fifo.sv
// Single-clock FIFO with registered read data and a shared occupancy count.
// Full/Empty decode the registered count, so they only move on clock edges.
module rw_fifo
    import rw_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] Data,
    input  logic              WrEn,
    input  logic              RdEn,
    output logic [DATA_W-1:0] Q,
    output logic [CNT_W-1:0]  Wnum,
    output logic [CNT_W-1:0]  Rnum,
    output logic              Full,
    output logic              Empty
);

    localparam int PTR_W = $clog2(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("rw_fifo: DEPTH must be a power of two");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_ok;
    logic             rd_ok;

    assign Full  = (count == CNT_W'(DEPTH));
    assign Empty = (count == '0);

    // Reset wins over both requests, so nothing is accepted while Reset_n is low.
    assign wr_ok = Reset_n && WrEn && !Full;
    assign rd_ok = Reset_n && RdEn && !Empty;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign Wnum = count;
    assign Rnum = count;

    rw_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (Clk),
        .rst_n (Reset_n),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (Data),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (Q)
    );

endmodule

// File: tb/tb_rw_fifo.sv
// Directed bench for rw_fifo: reset, ordering, full/empty boundaries, streaming with
// pointer wrap, and reset taking priority over requests.
module tb_rw_fifo;
    import rw_fifo_pkg::*;

    localparam int DATA_W = DEF_DATA_W;
    localparam int DEPTH  = DEF_DEPTH;
    localparam int CNT_W  = DEF_CNT_W;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic [DATA_W-1:0] Data;
    logic              WrEn;
    logic              RdEn;
    logic [DATA_W-1:0] Q;
    logic [CNT_W-1:0]  Wnum;
    logic [CNT_W-1:0]  Rnum;
    logic              Full;
    logic              Empty;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference FIFO contents and the Q value it implies.
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] exp_q;
    int                exp_cnt;

    always #5 Clk = ~Clk;

    rw_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Data    (Data),
        .WrEn    (WrEn),
        .RdEn    (RdEn),
        .Q       (Q),
        .Wnum    (Wnum),
        .Rnum    (Rnum),
        .Full    (Full),
        .Empty   (Empty)
    );

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) begin
            w[i*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    function automatic void model_reset();
        sb.delete();
        exp_q   = '0;
        exp_cnt = 0;
    endfunction

    // Acceptance decided on the pre-edge count, as the FIFO does.
    function automatic void model_step(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
        bit wr_ok;
        bit rd_ok;
        wr_ok = wr && (exp_cnt < DEPTH);
        rd_ok = rd && (exp_cnt > 0);
        if (rd_ok) begin
            exp_q = sb.pop_front();
        end
        if (wr_ok) begin
            sb.push_back(d);
        end
        exp_cnt = exp_cnt + int'(wr_ok) - int'(rd_ok);
    endfunction

    task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
        WrEn = wr;
        RdEn = rd;
        Data = d;
        model_step(wr, rd, d);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        WrEn    = 1'b0;
        RdEn    = 1'b0;
        Data    = '0;
        repeat (100) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, '0);
        tests_run++;
        if (Q !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_q got=%h want=0", Q);
        end
        tests_run++;
        if (Wnum !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wnum got=%0d want=0", Wnum);
        end
        tests_run++;
        if (Rnum !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rnum got=%0d want=0", Rnum);
        end
        tests_run++;
        if (Empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_empty got=%b want=1", Empty);
        end
        tests_run++;
        if (Full !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_full got=%b want=0", Full);
        end
    endtask

    task automatic test_basic_order();
        step(1'b1, 1'b0, DATA_W'(1));
        step(1'b1, 1'b0, DATA_W'(2));
        step(1'b1, 1'b0, DATA_W'(3));
        tests_run++;
        if (Rnum !== CNT_W'(3) || Wnum !== CNT_W'(3)) begin
            tests_failed++;
            $display("[TB] FAIL basic_count3 got wnum=%0d rnum=%0d want=3", Wnum, Rnum);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, '0);
            tests_run++;
            if (Q !== DATA_W'(k)) begin
                tests_failed++;
                $display("[TB] FAIL basic_q%0d got=%h want=%0d", k, Q, k);
            end
            tests_run++;
            if (Rnum !== CNT_W'(3 - k)) begin
                tests_failed++;
                $display("[TB] FAIL basic_rnum%0d got=%0d want=%0d", k, Rnum, 3 - k);
            end
        end
        tests_run++;
        if (Empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_empty got=%b want=1", Empty);
        end
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] words [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = rand_word();
            step(1'b1, 1'b0, words[i]);
        end
        tests_run++;
        if (Full !== 1'b1 || Wnum !== CNT_W'(DEPTH)) begin
            tests_failed++;
            $display("[TB] FAIL full_reached got full=%b wnum=%0d want full=1 wnum=%0d", Full, Wnum, DEPTH);
        end
        step(1'b1, 1'b0, rand_word());
        tests_run++;
        if (Full !== 1'b1 || Wnum !== CNT_W'(DEPTH)) begin
            tests_failed++;
            $display("[TB] FAIL full_drop got full=%b wnum=%0d want full=1 wnum=%0d", Full, Wnum, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0);
            tests_run++;
            if (Q !== words[i]) begin
                tests_failed++;
                $display("[TB] FAIL full_read%0d got=%h want=%h", i, Q, words[i]);
            end
        end
        tests_run++;
        if (Empty !== 1'b1 || Rnum !== '0) begin
            tests_failed++;
            $display("[TB] FAIL full_drain got empty=%b rnum=%0d want empty=1 rnum=0", Empty, Rnum);
        end
    endtask

    task automatic test_empty_and_simul();
        logic [DATA_W-1:0] held;
        held = exp_q;
        step(1'b0, 1'b1, '0);
        tests_run++;
        if (Q !== held || Rnum !== '0) begin
            tests_failed++;
            $display("[TB] FAIL empty_read got q=%h cnt=%0d want q=%h cnt=0", Q, Rnum, held);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, DATA_W'(32'h10 + i));
        end
        step(1'b1, 1'b1, DATA_W'(32'h20));
        tests_run++;
        if (Rnum !== CNT_W'(5) || Q !== DATA_W'(32'h10)) begin
            tests_failed++;
            $display("[TB] FAIL simul_rw got cnt=%0d q=%h want cnt=5 q=10", Rnum, Q);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, '0);
            tests_run++;
            if (Q !== exp_q) begin
                tests_failed++;
                $display("[TB] FAIL simul_drain%0d got=%h want=%h", i, Q, exp_q);
            end
        end
    endtask

    task automatic test_stream_wrap();
        int writes = 0;
        int reads  = 0;
        int cyc    = 0;
        bit rd;
        while (writes < 1024) begin
            if (cyc % 2 == 0) begin
                rd = (exp_cnt >= 233);
                step(1'b1, rd, DATA_W'(32'h1000 + writes));
                writes++;
                if (rd) begin
                    tests_run++;
                    if (Q !== DATA_W'(32'h1000 + reads) || Wnum !== CNT_W'(233)) begin
                        tests_failed++;
                        $display("[TB] FAIL stream_rw%0d got q=%h cnt=%0d want q=%h cnt=233", reads, Q, Wnum, 32'h1000 + reads);
                    end
                    reads++;
                end
            end else begin
                step(1'b0, 1'b0, '0);
            end
            cyc++;
        end
        while (reads < 1024 && exp_cnt > 0) begin
            step(1'b0, 1'b1, '0);
            tests_run++;
            if (Q !== DATA_W'(32'h1000 + reads)) begin
                tests_failed++;
                $display("[TB] FAIL stream_drain%0d got=%h want=%h", reads, Q, 32'h1000 + reads);
            end
            reads++;
        end
        tests_run++;
        if (reads !== 1024 || Empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stream_end got reads=%0d empty=%b want reads=1024 empty=1", reads, Empty);
        end
    endtask

    task automatic test_reset_priority();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, DATA_W'(32'h200 + i));
        end
        tests_run++;
        if (Wnum !== CNT_W'(100)) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_pre got=%0d want=100", Wnum);
        end
        Reset_n = 1'b0;
        WrEn    = 1'b1;
        RdEn    = 1'b1;
        Data    = DATA_W'(32'hDEAD);
        model_reset();
        @(posedge Clk);
        #1;
        tests_run++;
        if (Wnum !== '0 || Rnum !== '0 || Q !== '0 || Empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_state got wnum=%0d rnum=%0d q=%h empty=%b want 0 0 0 1", Wnum, Rnum, Q, Empty);
        end
        Reset_n = 1'b1;
        step(1'b0, 1'b0, '0);
        tests_run++;
        if (Wnum !== '0 || Empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_nowrite got wnum=%0d empty=%b want 0 1", Wnum, Empty);
        end
        step(1'b1, 1'b0, DATA_W'(32'h55));
        step(1'b0, 1'b1, '0);
        tests_run++;
        if (Q !== DATA_W'(32'h55) || Rnum !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_after got q=%h cnt=%0d want q=55 cnt=0", Q, Rnum);
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_full();
        test_empty_and_simul();
        test_stream_wrap();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rw_fifo.md
RW_FIFO -- requirements
Module: rw_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DATA_W, default 256, SHALL set the data word width in bits.
REQ-003 Parameter DEPTH, default 512, SHALL set the storage depth in words; it SHALL be a power of 2.
REQ-004 Parameter CNT_W, default 10 (= log2(DEPTH)+1), SHALL set the occupancy count width.
REQ-005 Port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port Reset_n, input, 1 bit: synchronous active-low reset.
REQ-007 Port Data, input, DATA_W bits: write data.
REQ-008 Port WrEn, input, 1 bit: write request.
REQ-009 Port RdEn, input, 1 bit: read request.
REQ-010 Port Q, output, DATA_W bits: registered read data.
REQ-011 Port Wnum, output, CNT_W bits: occupancy on the write side, in words.
REQ-012 Port Rnum, output, CNT_W bits: occupancy on the read side, in words.
REQ-013 Port Full, output, 1 bit: high when occupancy equals DEPTH.
REQ-014 Port Empty, output, 1 bit: high when occupancy is 0.

Function
REQ-015 Ordering SHALL be first-in first-out, with no data loss or duplication.
REQ-016 Write acceptance SHALL be wr_ok = WrEn && !Full; each accepted write SHALL store Data at the write pointer and increment it modulo DEPTH.
REQ-017 Read acceptance SHALL be rd_ok = RdEn && !Empty; each accepted read SHALL load Q on the same edge with the word at the read pointer (Q valid 1 cycle after RdEn sampled) and increment the read pointer modulo DEPTH.
REQ-018 Q SHALL hold its last value when no read is accepted, including a read requested while empty.
REQ-019 A write requested while full SHALL be dropped, leaving memory and pointers unchanged.
REQ-020 Full and Empty SHALL be evaluated on pre-edge state.
- Simultaneous wr_ok and rd_ok SHALL leave occupancy unchanged.
- At Full, only the read proceeds; at Empty, only the write proceeds (no read-through).
REQ-021 Occupancy SHALL increment on wr_ok only, decrement on rd_ok only, and stay unchanged otherwise; its range SHALL be 0..DEPTH.
REQ-022 Wnum and Rnum SHALL both equal the registered occupancy and change on the edge after the causing request.
REQ-023 Pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without affecting data order.
REQ-024 Full and Empty SHALL be registered or derived combinationally from the registered occupancy, and SHALL never glitch high and low within a cycle.

Reset
REQ-025 While Reset_n is sampled low, the block SHALL clear pointers and occupancy to 0 and set Q to 0.
REQ-026 During reset, Wnum = Rnum = 0, Empty = 1 and Full = 0.
REQ-027 Storage memory SHALL NOT be reset; its contents are discarded logically.
REQ-028 Reset asserted mid-operation SHALL take priority over WrEn and RdEn in that cycle, so no write or read is accepted.
REQ-029 The first accepted write SHALL be possible in the cycle after Reset_n is sampled high.

Structure
REQ-030 A shared package rw_fifo_pkg SHALL hold the default DATA_W, DEPTH and CNT_W constants.
REQ-031 A sub-module rw_fifo_mem SHALL implement the storage.
- Simple dual-port RAM, DEPTH x DATA_W.
- One synchronous write port and one synchronous read port, with a read-enable gating the registered output.
- Block-RAM inferable.

Verification
REQ-032 Reset 100 cycles then release, no requests -> Q=0, Wnum=Rnum=0, Empty=1, Full=0.
REQ-033 Write 0x1,0x2,0x3 on consecutive cycles, then read 3 -> Q=0x1,0x2,0x3 one cycle after each RdEn; Rnum goes 3,2,1,0; Empty=1 at the end.
REQ-034 Write 512 random words -> Full=1, Wnum=512; a 513th write is dropped; reading 512 returns all 512 words in order.
REQ-035 Alternating write/idle from empty, with RdEn added once 233 words are stored, for 1024 writes total -> occupancy holds at 233 while write and read run together; all words are read back in order; pointers wrap twice.
REQ-036 RdEn while empty -> Q unchanged and count stays 0; simultaneous WrEn+RdEn at count 5 -> count stays 5 and Q is the oldest word.
REQ-037 Reset_n low for 1 cycle with count 100 and WrEn=RdEn=1 -> next cycle count=0, Q=0, Empty=1, and no write is accepted in the reset cycle.
